// File: rtl/bmux_pipe_if.sv
// Stream bundle for bmux_pipe: the offer side (din/sel/in_valid/in_ready)
// and the result side (out_data/out_sel/out_valid/out_ready).
// slave is the mux block's view; master is the surrounding datapath's view.
interface bmux_pipe_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
);
    logic [NUM_IN*WIDTH-1:0] din;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  din, sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output din, sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/bmux_pipe.sv
// bmux_pipe: N-way, W-bit select multiplexer feeding a 2-entry skid buffer
// (main register M drives the outputs, skid register S holds one overflow).
// in_ready is registered, so no combinational ready path crosses the block.
// Optional feature macro: BMUX_PIPE_SEL_ERR_EN -- drops out-of-range selects
// and raises a sticky sel_err flag, cleared by err_clr (a new error wins).
module bmux_pipe #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef BMUX_PIPE_SEL_ERR_EN
    input  logic         err_clr,
    output logic         sel_err,
`endif
    bmux_pipe_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_data_q, m_data_d;
    logic [SEL_W-1:0]   m_sel_q, m_sel_d;
    logic [WIDTH-1:0]   s_data_q, s_data_d;
    logic [SEL_W-1:0]   s_sel_q, s_sel_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   mux_data_s;
    logic               in_xfer_s;
    logic               accept_s;
    logic               out_xfer_s;

    // Selected input, or all zeros when sel names no existing input.
    function automatic logic [WIDTH-1:0] mux_sel(
        input logic [NUM_IN*WIDTH-1:0] din_f,
        input logic [SEL_W-1:0]        sel_f
    );
        logic [WIDTH-1:0] res;
        res = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_f == SEL_W'(k)) begin
                res = din_f[k*WIDTH +: WIDTH];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign mux_data_s = mux_sel(bus.din, bus.sel);
    assign in_xfer_s  = bus.in_valid & in_ready_q;
    assign out_xfer_s = out_valid_q & bus.out_ready;

`ifdef BMUX_PIPE_SEL_ERR_EN
    logic sel_bad_s;
    logic sel_err_q, sel_err_d;

    // An out-of-range select still completes the handshake but is not enqueued.
    assign sel_bad_s = ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_IN));
    assign accept_s  = in_xfer_s & ~sel_bad_s;

    // Sticky error flag: a new error takes priority over a clear request.
    always_comb begin
        sel_err_d = sel_err_q;
        if (in_xfer_s && sel_bad_s) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // Error flag register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign accept_s = in_xfer_s;
`endif

    // Skid-buffer next state: fill M first, overflow into S, refill M from S.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_sel_d  = m_sel_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d  = ST_ONE;
                    m_data_d = mux_data_s;
                    m_sel_d  = bus.sel;
                end else begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && out_xfer_s) begin
                    state_d  = ST_ONE;
                    m_data_d = mux_data_s;
                    m_sel_d  = bus.sel;
                end else if (accept_s) begin
                    state_d  = ST_TWO;
                    s_data_d = mux_data_s;
                    s_sel_d  = bus.sel;
                end else if (out_xfer_s) begin
                    state_d  = ST_EMPTY;
                end else begin
                    state_d  = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain can happen.
                if (out_xfer_s) begin
                    state_d  = ST_ONE;
                    m_data_d = s_data_q;
                    m_sel_d  = s_sel_q;
                end else begin
                    state_d  = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Buffer and handshake registers; reset discards any buffered data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            m_data_q    <= {WIDTH{1'b0}};
            m_sel_q     <= {SEL_W{1'b0}};
            s_data_q    <= {WIDTH{1'b0}};
            s_sel_q     <= {SEL_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_sel_q     <= m_sel_d;
            s_data_q    <= s_data_d;
            s_sel_q     <= s_sel_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = m_data_q;
    assign bus.out_sel   = m_sel_q;

endmodule
